// File: rtl/ppm_frame_encoder_m_pkg.sv
// Shared types and helpers for the L-PPM frame encoder.
// One-hot state encoding plus default framing patterns.
package ppm_frame_encoder_m_pkg;

  localparam int ST_IDLE_B = 0;
  localparam int ST_LOAD_B = 1;
  localparam int ST_SOF_B  = 2;
  localparam int ST_DATA_B = 3;
  localparam int ST_EOF_B  = 4;

  typedef enum logic [4:0] {
    ST_IDLE = 5'b00001,
    ST_LOAD = 5'b00010,
    ST_SOF  = 5'b00100,
    ST_DATA = 5'b01000,
    ST_EOF  = 5'b10000
  } state_t;

  localparam logic [3:0] SOF_DEF = 4'b0111;
  localparam logic [3:0] EOF_DEF = 4'b1101;

  function automatic int sym_per_byte(input int m);
    return 8 / m;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int r;
    r = (a > b) ? a : b;
    return (r > c) ? r : c;
  endfunction

endpackage

// File: rtl/ppm_frame_encoder_m_if.sv
// Byte load port of the PPM frame encoder.
// Plain valid/ready handshake with a frame-end marker.
interface ppm_frame_encoder_m_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_last;

  modport master (
    output in_valid,
    output in_data,
    output in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_last,
    output in_ready
  );
endinterface

// File: rtl/ppm_frame_encoder_m_slot_serialiser.sv
// Slot timer and symbol shaper: one strobe emits a 2^M-slot PPM symbol,
// or a single pattern slot when pat_mode is set (level = sym MSB).
module ppm_slot_serialiser #(
  parameter int M           = 2,
  parameter int SLOT_CYCLES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         sym_strobe,
  input  logic         pat_mode,
  input  logic [M-1:0] sym,
  output logic         line,
  output logic         sym_done
);

  localparam int CW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(SLOT_CYCLES - 1);

  logic          act_q, act_d;
  logic          pat_q, pat_d;
  logic          line_q, line_d;
  logic [M-1:0]  sym_q, sym_d;
  logic [M-1:0]  slot_q, slot_d;
  logic [M-1:0]  slot_nx;
  logic [CW-1:0] cyc_q, cyc_d;
  logic          slot_end;

  assign slot_end = act_q && (cyc_q == CYC_LAST);
  assign sym_done = slot_end && (pat_q || (slot_q == '1));
  assign slot_nx  = slot_q + M'(1);

  always_comb begin
    act_d  = act_q;
    pat_d  = pat_q;
    sym_d  = sym_q;
    slot_d = slot_q;
    cyc_d  = cyc_q;
    line_d = line_q;
    if (sym_strobe) begin
      act_d  = 1'b1;
      pat_d  = pat_mode;
      sym_d  = sym;
      cyc_d  = '0;
      slot_d = '0;
      line_d = pat_mode ? sym[M-1] : (sym != '0);
    end else if (slot_end) begin
      cyc_d = '0;
      if (sym_done) begin
        act_d  = 1'b0;
        line_d = 1'b1;
      end else begin
        slot_d = slot_nx;
        line_d = (slot_nx != sym_q);
      end
    end else if (act_q) begin
      cyc_d = cyc_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_q  <= 1'b0;
      pat_q  <= 1'b0;
      sym_q  <= '0;
      slot_q <= '0;
      cyc_q  <= '0;
      line_q <= 1'b1;
    end else begin
      act_q  <= act_d;
      pat_q  <= pat_d;
      sym_q  <= sym_d;
      slot_q <= slot_d;
      cyc_q  <= cyc_d;
      line_q <= line_d;
    end
  end

  assign line = line_q;

endmodule

// File: rtl/ppm_frame_encoder_m.sv
// L-PPM frame transmitter: buffers a byte frame, then sends
// SOF pattern, 2^M-slot data symbols and EOF pattern on dout.
module ppm_frame_encoder_m
  import ppm_frame_encoder_m_pkg::*;
#(
  parameter int BITS_PER_SYM = 2,
  parameter int SLOT_CYCLES  = 4,
  parameter int MAX_BYTES    = 16,
  parameter int SOF_SLOTS    = 4,
  parameter logic [SOF_SLOTS-1:0] SOF_PATTERN = SOF_DEF,
  parameter int EOF_SLOTS    = 4,
  parameter logic [EOF_SLOTS-1:0] EOF_PATTERN = EOF_DEF,
  localparam int BW = $clog2(MAX_BYTES + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ppm_frame_encoder_m_if.slave  ld,
  output logic                  busy,
  output logic                  frame_done,
  output logic [BW-1:0]         byte_cnt,
  output logic                  dout
);

  localparam int M   = BITS_PER_SYM;
  localparam int SPB = sym_per_byte(M);
  localparam int AW  = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
  localparam int SW  = max3(8, SOF_SLOTS, EOF_SLOTS);
  localparam int IW  = $clog2(max3(SPB, SOF_SLOTS, EOF_SLOTS) + 1);

  // Patterns and bytes are left-aligned so the next slot/symbol is always at the top.
  localparam logic [SW-1:0] SOF_ALN = SW'(SOF_PATTERN) << (SW - SOF_SLOTS);
  localparam logic [SW-1:0] EOF_ALN = SW'(EOF_PATTERN) << (SW - EOF_SLOTS);
  localparam logic [IW-1:0] SOF_N   = IW'(SOF_SLOTS);
  localparam logic [IW-1:0] EOF_N   = IW'(EOF_SLOTS);
  localparam logic [IW-1:0] SPB_N   = IW'(SPB);
  localparam logic [BW-1:0] FULL_M1 = BW'(MAX_BYTES - 1);

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [BW-1:0] rd_q, rd_d;
  logic [BW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] sh_q, sh_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          rdy_q, rdy_d;
  logic [7:0]    mem_q [MAX_BYTES];

  logic [SW-1:0] nxt;
  logic [SW-1:0] rd_aln;
  logic [M-1:0]  sym;
  logic          strobe, pmode;
  logic          accept, last_acc;
  logic          sym_done, line;

  assign accept   = rdy_q & ld.in_valid;
  assign last_acc = accept & (ld.in_last | (cnt_q == FULL_M1));
  assign rd_aln   = SW'(mem_q[rd_q[AW-1:0]]) << (SW - 8);
  assign sym      = nxt[SW-1 -: M];

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    nxt     = sh_q;
    strobe  = 1'b0;
    pmode   = 1'b0;
    unique case (1'b1)
      state_q[ST_IDLE_B], state_q[ST_LOAD_B]: begin
        if (accept) begin
          cnt_d   = cnt_q + BW'(1);
          state_d = ST_LOAD;
          if (last_acc) begin
            state_d = ST_SOF;
            nxt     = SOF_ALN;
            strobe  = 1'b1;
            pmode   = 1'b1;
            idx_d   = IW'(1);
          end
        end
      end
      state_q[ST_SOF_B]: begin
        if (sym_done) begin
          strobe = 1'b1;
          if (idx_q == SOF_N) begin
            state_d = ST_DATA;
            nxt     = rd_aln;
            rd_d    = rd_q + BW'(1);
            idx_d   = IW'(1);
          end else begin
            pmode = 1'b1;
            idx_d = idx_q + IW'(1);
          end
        end
      end
      state_q[ST_DATA_B]: begin
        if (sym_done) begin
          strobe = 1'b1;
          if (idx_q != SPB_N) begin
            idx_d = idx_q + IW'(1);
          end else if (rd_q == cnt_q) begin
            state_d = ST_EOF;
            nxt     = EOF_ALN;
            pmode   = 1'b1;
            idx_d   = IW'(1);
          end else begin
            nxt   = rd_aln;
            rd_d  = rd_q + BW'(1);
            idx_d = IW'(1);
          end
        end
      end
      state_q[ST_EOF_B]: begin
        if (sym_done) begin
          if (idx_q == EOF_N) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            cnt_d   = '0;
            rd_d    = '0;
            idx_d   = '0;
          end else begin
            strobe = 1'b1;
            pmode  = 1'b1;
            idx_d  = idx_q + IW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    sh_d = sh_q;
    if (strobe) sh_d = pmode ? (nxt << 1) : (nxt << M);
  end

  // in_ready stays low through the frame_done cycle.
  always_comb begin
    rdy_d  = (state_q[ST_IDLE_B] | state_q[ST_LOAD_B]) &
             (state_d[ST_IDLE_B] | state_d[ST_LOAD_B]);
    busy_d = ~state_d[ST_IDLE_B];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      sh_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rdy_q   <= rdy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem_q[cnt_q[AW-1:0]] <= ld.in_data;
  end

  ppm_slot_serialiser #(
    .M           (M),
    .SLOT_CYCLES (SLOT_CYCLES)
  ) u_ser (
    .clk        (clk),
    .rst_n      (rst_n),
    .sym_strobe (strobe),
    .pat_mode   (pmode),
    .sym        (sym),
    .line       (line),
    .sym_done   (sym_done)
  );

  assign ld.in_ready = rdy_q;
  assign busy        = busy_q;
  assign frame_done  = done_q;
  assign byte_cnt    = cnt_q;
  assign dout        = line;

endmodule

// File: tb/tb_ppm_frame_encoder_m.sv
// Randomised bench for the PPM frame encoder against a slot-level
// waveform model; covers default and M=1/SLOT_CYCLES=1 builds.
module tb_ppm_frame_encoder_m;

  typedef logic [7:0] bq_t[$];
  typedef bit wq_t[$];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       tb_valid = 1'b0;
  logic       tb_last  = 1'b0;
  logic       tb_sel   = 1'b0;
  logic [7:0] tb_data  = 8'h00;

  ppm_frame_encoder_m_if ifa ();
  ppm_frame_encoder_m_if ifb ();

  assign ifa.in_valid = tb_valid & ~tb_sel;
  assign ifb.in_valid = tb_valid & tb_sel;
  assign ifa.in_data  = tb_data;
  assign ifb.in_data  = tb_data;
  assign ifa.in_last  = tb_last;
  assign ifb.in_last  = tb_last;

  logic       busy0, done0, dout0;
  logic       busy1, done1, dout1;
  logic [4:0] cnt0;
  logic [2:0] cnt1;

  ppm_frame_encoder_m dut0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .ld         (ifa),
    .busy       (busy0),
    .frame_done (done0),
    .byte_cnt   (cnt0),
    .dout       (dout0)
  );

  ppm_frame_encoder_m #(
    .BITS_PER_SYM (1),
    .SLOT_CYCLES  (1),
    .MAX_BYTES    (4)
  ) dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .ld         (ifb),
    .busy       (busy1),
    .frame_done (done1),
    .byte_cnt   (cnt1),
    .dout       (dout1)
  );

  logic o_rdy, o_busy, o_done, o_dout;
  int   o_cnt;
  assign o_rdy  = tb_sel ? ifb.in_ready : ifa.in_ready;
  assign o_busy = tb_sel ? busy1 : busy0;
  assign o_done = tb_sel ? done1 : done0;
  assign o_dout = tb_sel ? dout1 : dout0;
  assign o_cnt  = tb_sel ? int'(cnt1) : int'(cnt0);

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Expected line level for every clock of the frame, from first SOF cycle.
  function automatic void build_wave(input bq_t b, input int m,
                                     input int sc, output wq_t w);
    logic [3:0] sofp = 4'b0111;
    logic [3:0] eofp = 4'b1101;
    int v;
    w = {};
    for (int k = 0; k < 4; k++)
      for (int c = 0; c < sc; c++) w.push_back(sofp[3-k]);
    foreach (b[i])
      for (int s = 0; s < 8 / m; s++) begin
        v = (int'(b[i]) >> (8 - m * (s + 1))) & ((1 << m) - 1);
        for (int sl = 0; sl < (1 << m); sl++)
          for (int c = 0; c < sc; c++) w.push_back(sl != v);
      end
    for (int k = 0; k < 4; k++)
      for (int c = 0; c < sc; c++) w.push_back(eofp[3-k]);
  endfunction

  task automatic wait_idle();
    int t = 0;
    while (!o_rdy && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("idle_wait", int'(o_rdy), 1);
  endtask

  task automatic do_reset();
    tb_valid = 1'b0;
    tb_last  = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk("rst_dout", int'(o_dout), 1);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_cnt", o_cnt, 0);
    chk("rst_ready", int'(o_rdy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_post_rst", int'(o_rdy), 1);
  endtask

  task automatic run_frame(input bq_t bytes, input bit use_last,
                           input bit hold);
    bq_t acc;
    wq_t w;
    int  m, sc, maxb, nd, nc;
    bit  hld, extra;
    m    = tb_sel ? 1 : 2;
    sc   = tb_sel ? 1 : 4;
    maxb = tb_sel ? 4 : 16;
    nd   = 0;
    nc   = 0;
    hld  = hold;
    acc  = {};
    wait_idle();
    foreach (bytes[i]) begin
      tb_valid = 1'b1;
      tb_data  = bytes[i];
      tb_last  = use_last && (i == bytes.size() - 1);
      if (!o_rdy) break;
      @(posedge clk);
      acc.push_back(bytes[i]);
      if (tb_last || acc.size() == maxb) break;
      @(negedge clk);
    end
    extra = (acc.size() < bytes.size());
    #1;
    if (extra) begin
      hld     = 1'b1;
      tb_data = bytes[acc.size()];
      tb_last = 1'b0;
    end else if (hld) begin
      tb_data = 8'hC3;
      tb_last = 1'b1;
    end else begin
      tb_valid = 1'b0;
      tb_last  = 1'b0;
    end
    build_wave(acc, m, sc, w);
    for (int k = 0; k < w.size(); k++) begin
      @(negedge clk);
      if (k == 0 && extra) chk("ready_drop", int'(o_rdy), 0);
      if (o_dout !== w[k]) begin
        if (nd == 0) $display("dout first diff at frame cycle %0d", k);
        nd++;
      end
      if (o_done !== 1'b0 || o_busy !== 1'b1 || o_rdy !== 1'b0 ||
          o_cnt != acc.size()) nc++;
    end
    chk("dout_wave", nd, 0);
    chk("ctl_during_tx", nc, 0);
    @(negedge clk);
    chk("frame_done", int'(o_done), 1);
    chk("busy_end", int'(o_busy), 0);
    chk("cnt_end", o_cnt, 0);
    chk("ready_on_done", int'(o_rdy), 0);
    chk("dout_idle", int'(o_dout), 1);
    @(negedge clk);
    chk("done_pulse", int'(o_done), 0);
    chk("ready_after_done", int'(o_rdy), 1);
    if (hld) begin
      @(negedge clk);
      chk("reload_after_done", o_cnt, 1);
      chk("busy_reload", int'(o_busy), 1);
      do_reset();
    end
  endtask

  initial begin
    #950000;
    $display("FAIL timeout: no finish after %0d ns", 950000);
    $fatal(1, "timeout");
  end

  initial begin
    bq_t q;
    int  len;
    bit  ul;
    #12;
    chk("reset_dout", int'(dout0), 1);
    chk("reset_ready", int'(ifa.in_ready), 0);
    chk("reset_busy", int'(busy0), 0);
    chk("reset_cnt", int'(cnt0), 0);
    chk("reset_done", int'(done0), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_idle", int'(ifa.in_ready), 1);

    tb_sel = 1'b0;
    q = {8'h1B};
    run_frame(q, 1'b1, 1'b0);
    q = {8'hFF, 8'h00, 8'hA5};
    run_frame(q, 1'b1, 1'b0);

    q = {};
    for (int i = 0; i < 17; i++) q.push_back(8'($urandom));
    run_frame(q, 1'b0, 1'b0);

    q = {8'($urandom), 8'($urandom)};
    run_frame(q, 1'b1, 1'b1);

    // Abort a frame while a data symbol drives the line low.
    wait_idle();
    q = {8'h00, 8'h00};
    foreach (q[i]) begin
      tb_valid = 1'b1;
      tb_data  = q[i];
      tb_last  = (i == 1);
      @(posedge clk);
      @(negedge clk);
    end
    tb_valid = 1'b0;
    tb_last  = 1'b0;
    repeat (20) @(negedge clk);
    for (int t = 0; t < 64 && dout0 !== 1'b0; t++) @(negedge clk);
    chk("mid_data_low", int'(dout0), 0);
    chk("mid_data_busy", int'(busy0), 1);
    do_reset();
    q = {8'h5A, 8'h3C};
    run_frame(q, 1'b1, 1'b0);

    for (int f = 0; f < 8; f++) begin
      len = $urandom_range(1, 16);
      q = {};
      for (int i = 0; i < len; i++) q.push_back(8'($urandom));
      ul = (len < 16) || ($urandom_range(0, 1) == 1);
      run_frame(q, ul, 1'b0);
    end

    wait_idle();
    @(negedge clk);
    tb_sel = 1'b1;
    @(negedge clk);
    q = {8'h80};
    run_frame(q, 1'b1, 1'b0);
    for (int f = 0; f < 6; f++) begin
      len = $urandom_range(1, 4);
      q = {};
      for (int i = 0; i < len; i++) q.push_back(8'($urandom));
      run_frame(q, 1'b1, 1'b0);
    end
    q = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    run_frame(q, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
